// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for seven-segment display blocks.
//   - SEG_0..SEG_9, SEG_BLANK : active-low segment patterns, bit order
//                               {g,f,e,d,c,b,a}.
//   - cnt_width()             : register width for a counter that runs
//                               0..limit-1 (never narrower than 1 bit).
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // A limit of 1 still needs a 1-bit register so the counter stays legal.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bcd_seg7_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_seg7_counter_if
// Control and display bundle of bcd_seg7_counter.
//   en, up, clear : run enable, count direction, synchronous clear
//   value         : registered BCD count, digit 0 in [3:0]
//   wrap          : one-cycle pulse when the count wraps
//   seg, an, dp   : active-low segments, anodes and decimal point
// Handshake: none. Controls are level-sensitive and sampled on every
// rising clock edge; all outputs are registered and valid every cycle
// outside reset.
// master = controller/board side, slave = the counter.
// ---------------------------------------------------------------------------
interface bcd_seg7_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  clear;
    logic [4*DIGITS-1:0]   value;
    logic                  wrap;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  dp;

    modport master (
        output en, up, clear,
        input  value, wrap, seg, an, dp
    );

    modport slave (
        input  en, up, clear,
        output value, wrap, seg, an, dp
    );
endinterface

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to seven-segment decoder, common-anode (active-low).
//   i_bcd : 4-bit BCD digit
//   o_seg : {g,f,e,d,c,b,a}, 0 = segment lit. Codes 10..15 are blank.
// ---------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_counter.sv
// ---------------------------------------------------------------------------
// bcd_seg7_counter
// DIGITS-wide BCD up/down counter advanced by a two-stage prescaler
// (clocks -> ms ticks -> count steps), with a free-running scanned
// common-anode seven-segment output.
//   clk, rst : system clock; asynchronous active-high reset
//   bus      : slave side of bcd_seg7_counter_if
//              en/up/clear in; value/wrap/seg/an/dp out
// Parameters: CLK_PER_MS (>=2), MS_PER_STEP (>=1), DIGITS (1..8),
//             SCAN_DIV (>=1).
// ---------------------------------------------------------------------------
module bcd_seg7_counter
    import seg7_pkg::*;
#(
    parameter int CLK_PER_MS  = 100000,
    parameter int MS_PER_STEP = 1000,
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 100000
) (
    input  logic               clk,
    input  logic               rst,
    bcd_seg7_counter_if.slave  bus
);

    localparam int MS_W  = cnt_width(CLK_PER_MS);
    localparam int ST_W  = cnt_width(MS_PER_STEP);
    localparam int SC_W  = cnt_width(SCAN_DIV);
    localparam int DIG_W = cnt_width(DIGITS);

    logic [MS_W-1:0]       r_ms_cnt;
    logic [ST_W-1:0]       r_st_cnt;
    logic [SC_W-1:0]       r_sc_cnt;
    logic [DIG_W-1:0]      r_digit;
    logic [4*DIGITS-1:0]   r_value;
    logic                  r_wrap;
    logic [6:0]            r_seg;
    logic [DIGITS-1:0]     r_an;

    logic                  w_ms_tick;
    logic                  w_step;
    logic [4*DIGITS-1:0]   w_value_next;
    logic                  w_carry;
    logic [3:0]            w_sel_digit;
    logic [6:0]            w_sel_seg;

    // ---------------- prescaler decode ----------------
    assign w_ms_tick = bus.en && (r_ms_cnt == MS_W'(CLK_PER_MS - 1));
    assign w_step    = w_ms_tick && (r_st_cnt == ST_W'(MS_PER_STEP - 1));

    // ---------------- BCD ripple chain ----------------
    // w_carry enters digit 0 set (the step itself) and stays set only while
    // every lower digit rolled over; if it survives the last digit the whole
    // count wrapped.
    always_comb begin
        w_value_next = r_value;
        w_carry      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (bus.up) begin
                    if (r_value[4*i +: 4] == 4'd9) begin
                        w_value_next[4*i +: 4] = 4'd0;
                    end else begin
                        w_value_next[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
                        w_carry = 1'b0;
                    end
                end else begin
                    if (r_value[4*i +: 4] == 4'd0) begin
                        w_value_next[4*i +: 4] = 4'd9;
                    end else begin
                        w_value_next[4*i +: 4] = r_value[4*i +: 4] - 4'd1;
                        w_carry = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- prescalers and count ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ms_cnt <= '0;
            r_st_cnt <= '0;
            r_value  <= '0;
            r_wrap   <= 1'b0;
        end else if (bus.clear) begin
            r_ms_cnt <= '0;
            r_st_cnt <= '0;
            r_value  <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_ms_tick) begin
                r_ms_cnt <= '0;
                if (w_step) begin
                    r_st_cnt <= '0;
                end else begin
                    r_st_cnt <= r_st_cnt + 1'b1;
                end
            end else if (bus.en) begin
                r_ms_cnt <= r_ms_cnt + 1'b1;
            end
            if (w_step) begin
                r_value <= w_value_next;
                r_wrap  <= w_carry;
            end
        end
    end

    // ---------------- scanner (ignores en/clear) ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sc_cnt <= '0;
            r_digit  <= '0;
        end else if (r_sc_cnt == SC_W'(SCAN_DIV - 1)) begin
            r_sc_cnt <= '0;
            if (r_digit == DIG_W'(DIGITS - 1)) begin
                r_digit <= '0;
            end else begin
                r_digit <= r_digit + 1'b1;
            end
        end else begin
            r_sc_cnt <= r_sc_cnt + 1'b1;
        end
    end

    // Mux written as a compare loop so DIGITS=1 needs no out-of-range slice.
    always_comb begin
        w_sel_digit = r_value[3:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit == DIG_W'(i)) begin
                w_sel_digit = r_value[4*i +: 4];
            end
        end
    end

    seg7_decode u_decode (
        .i_bcd (w_sel_digit),
        .o_seg (w_sel_seg)
    );

    // Display lags value/digit by one cycle so the pins come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_0;
            r_an  <= ~DIGITS'(1);
        end else begin
            r_seg <= w_sel_seg;
            r_an  <= ~(DIGITS'(1) << r_digit);
        end
    end

    assign bus.value = r_value;
    assign bus.wrap  = r_wrap;
    assign bus.seg   = r_seg;
    assign bus.an    = r_an;
    assign bus.dp    = 1'b1;

endmodule

// File: tb/tb_bcd_seg7_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_seg7_counter
// Two counters (DIGITS=2 and DIGITS=4, CLK_PER_MS=4, MS_PER_STEP=5,
// SCAN_DIV=3) share one stimulus stream. A decimal-integer model tracks
// both; a negedge process compares every output every cycle, and directed
// phases pin hand-computed literals on the 2-digit instance.
// ---------------------------------------------------------------------------
module tb_bcd_seg7_counter;

    localparam int CPM = 4;
    localparam int MPS = 5;
    localparam int SCD = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic en    = 1'b0;
    logic up    = 1'b1;
    logic clear = 1'b0;
    logic check_en = 1'b0;

    bcd_seg7_counter_if #(.DIGITS(2)) bus2 ();
    bcd_seg7_counter_if #(.DIGITS(4)) bus4 ();

    assign bus2.en = en;  assign bus2.up = up;  assign bus2.clear = clear;
    assign bus4.en = en;  assign bus4.up = up;  assign bus4.clear = clear;

    bcd_seg7_counter #(.CLK_PER_MS(CPM), .MS_PER_STEP(MPS), .DIGITS(2), .SCAN_DIV(SCD))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));
    bcd_seg7_counter #(.CLK_PER_MS(CPM), .MS_PER_STEP(MPS), .DIGITS(4), .SCAN_DIV(SCD))
        dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // ---------------- scoreboard bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic int digit_of(input int n, input int pos);
        int p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
        return (n / p) % 10;
    endfunction

    function automatic logic [31:0] to_bcd(input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'(digit_of(n, i));
        return r;
    endfunction

    int m_cnt2 = 0, m_cnt4 = 0, m_ms = 0, m_st = 0, m_sc = 0, m_d2 = 0, m_d4 = 0;
    logic m_wrap2 = 1'b0, m_wrap4 = 1'b0;
    logic [6:0] m_seg2 = 7'h40, m_seg4 = 7'h40;
    logic [1:0] m_an2 = 2'b10;
    logic [3:0] m_an4 = 4'b1110;

    always @(posedge clk or posedge rst) begin
        bit step;
        if (rst) begin
            m_cnt2 = 0; m_cnt4 = 0; m_ms = 0; m_st = 0; m_sc = 0;
            m_d2 = 0; m_d4 = 0; m_wrap2 = 1'b0; m_wrap4 = 1'b0;
            m_seg2 = seg_tbl[0]; m_seg4 = seg_tbl[0];
            m_an2 = 2'b10; m_an4 = 4'b1110;
        end else begin
            // display shows the state as it was before this edge
            m_seg2 = seg_tbl[digit_of(m_cnt2, m_d2)];
            m_seg4 = seg_tbl[digit_of(m_cnt4, m_d4)];
            m_an2  = ~(2'b01 << m_d2);
            m_an4  = ~(4'b0001 << m_d4);
            if (m_sc == SCD - 1) begin
                m_sc = 0;
                m_d2 = (m_d2 + 1) % 2;
                m_d4 = (m_d4 + 1) % 4;
            end else begin
                m_sc++;
            end
            if (clear) begin
                m_cnt2 = 0; m_cnt4 = 0; m_ms = 0; m_st = 0;
                m_wrap2 = 1'b0; m_wrap4 = 1'b0;
            end else begin
                m_wrap2 = 1'b0; m_wrap4 = 1'b0;
                step = 1'b0;
                if (en) begin
                    m_ms++;
                    if (m_ms == CPM) begin
                        m_ms = 0;
                        m_st++;
                        if (m_st == MPS) begin
                            m_st = 0;
                            step = 1'b1;
                        end
                    end
                end
                if (step) begin
                    if (up) begin
                        m_wrap2 = (m_cnt2 == 99);
                        m_wrap4 = (m_cnt4 == 9999);
                        m_cnt2  = (m_cnt2 + 1) % 100;
                        m_cnt4  = (m_cnt4 + 1) % 10000;
                    end else begin
                        m_wrap2 = (m_cnt2 == 0);
                        m_wrap4 = (m_cnt4 == 0);
                        m_cnt2  = (m_cnt2 + 99) % 100;
                        m_cnt4  = (m_cnt4 + 9999) % 10000;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en && !rst) begin
            chk("d2_value", 32'(bus2.value), to_bcd(m_cnt2));
            chk("d2_wrap",  32'(bus2.wrap),  32'(m_wrap2));
            chk("d2_seg",   32'(bus2.seg),   32'(m_seg2));
            chk("d2_an",    32'(bus2.an),    32'(m_an2));
            chk("d2_dp",    32'(bus2.dp),    32'd1);
            chk("d4_value", 32'(bus4.value), to_bcd(m_cnt4));
            chk("d4_wrap",  32'(bus4.wrap),  32'(m_wrap4));
            chk("d4_seg",   32'(bus4.seg),   32'(m_seg4));
            chk("d4_an",    32'(bus4.an),    32'(m_an4));
            chk("d4_dp",    32'(bus4.dp),    32'd1);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        cyc(3);
        rst = 1'b0;
        chk("rst_value", 32'(bus2.value), 32'h00);
        chk("rst_an",    32'(bus2.an),    32'b10);
        chk("rst_seg",   32'(bus2.seg),   32'b1000000);
        chk("rst_wrap",  32'(bus2.wrap),  32'd0);
        check_en = 1'b1;

        // count to 37 (20 clocks per step), then async reset mid-cycle
        en = 1'b1; up = 1'b1;
        cyc(740);
        chk("pre_rst_37", 32'(bus2.value), 32'h37);
        #3 rst = 1'b1;
        #1;
        chk("async_value", 32'(bus2.value), 32'h00);
        chk("async_an",    32'(bus2.an),    32'b10);
        chk("async_seg",   32'(bus2.seg),   32'b1000000);
        chk("async_wrap",  32'(bus2.wrap),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // up wrap: 99 after 99 steps, 00 with one-cycle wrap after 100
        cyc(1980);
        chk("up_99", 32'(bus2.value), 32'h99);
        cyc(19);
        chk("up_99_nowrap", 32'(bus2.wrap), 32'd0);
        cyc(1);
        chk("up_wrap_00",  32'(bus2.value), 32'h00);
        chk("up_wrap_hi",  32'(bus2.wrap),  32'd1);
        cyc(1);
        chk("up_wrap_lo",  32'(bus2.wrap),  32'd0);

        // down borrow: 10 -> 09, later 00 -> 99 with wrap
        cyc(199);
        chk("up_10", 32'(bus2.value), 32'h10);
        up = 1'b0;
        cyc(20);
        chk("dn_09", 32'(bus2.value), 32'h09);
        cyc(180);
        chk("dn_00", 32'(bus2.value), 32'h00);
        cyc(20);
        chk("dn_wrap_99", 32'(bus2.value), 32'h99);
        chk("dn_wrap_hi", 32'(bus2.wrap),  32'd1);
        cyc(1);
        chk("dn_wrap_lo", 32'(bus2.wrap),  32'd0);

        // freeze for 50 clocks mid-prescale (ms already at 1)
        en = 1'b0;
        cyc(50);
        chk("hold_99", 32'(bus2.value), 32'h99);
        en = 1'b1;
        cyc(18);
        clear = 1'b1;             // lands on the edge that would have stepped
        cyc(1);
        clear = 1'b0;
        chk("clr_value", 32'(bus2.value), 32'h00);
        chk("clr_wrap",  32'(bus2.wrap),  32'd0);
        cyc(19);
        chk("clr_no_step_yet", 32'(bus2.value), 32'h00);
        cyc(1);
        chk("clr_step_20", 32'(bus2.value), 32'h99);
        chk("clr_step_wrap", 32'(bus2.wrap), 32'd1);

        // scan with 42 held
        clear = 1'b1; up = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(840);
        chk("scan_42", 32'(bus2.value), 32'h42);
        en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (bus2.an == 2'b01) begin
                chk("scan_seg_4", 32'(bus2.seg), 32'b0011001);
            end else begin
                chk("scan_an_lo0", 32'(bus2.an), 32'b10);
                chk("scan_seg_2",  32'(bus2.seg), 32'b0100100);
            end
        end

        // random en/up/clear against the model
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            en    = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 199) == 0) up = ~up;
        end
        @(negedge clk);
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
